// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, R/W and ACK bit values, default device address.
package i2c_pkg;

   localparam int unsigned I2C_STATE_W = 4;

   localparam logic [I2C_STATE_W-1:0] I2C_ST_IDLE     = 4'd0;
   localparam logic [I2C_STATE_W-1:0] I2C_ST_ADDR     = 4'd1;
   localparam logic [I2C_STATE_W-1:0] I2C_ST_ADDR_ACK = 4'd2;
   localparam logic [I2C_STATE_W-1:0] I2C_ST_SUB      = 4'd3;
   localparam logic [I2C_STATE_W-1:0] I2C_ST_SUB_ACK  = 4'd4;
   localparam logic [I2C_STATE_W-1:0] I2C_ST_WR_DATA  = 4'd5;
   localparam logic [I2C_STATE_W-1:0] I2C_ST_WR_ACK   = 4'd6;
   localparam logic [I2C_STATE_W-1:0] I2C_ST_RD_DATA  = 4'd7;
   localparam logic [I2C_STATE_W-1:0] I2C_ST_RD_ACK   = 4'd8;
   localparam logic [I2C_STATE_W-1:0] I2C_ST_IGNORE   = 4'd9;

   localparam logic I2C_RW_WRITE = 1'b0;
   localparam logic I2C_RW_READ  = 1'b1;
   localparam logic I2C_ACK      = 1'b0;
   localparam logic I2C_NACK     = 1'b1;

   localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h5C;

   // Header byte is {addr[6:0], rw}
   function automatic logic i2c_addr_match(input logic [7:0] hdr, input logic [6:0] addr);
      return hdr[7:1] == addr;
   endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes scl/sda and produces registered edge, START and STOP pulses aligned with sda_s.
module i2c_bus_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_scl,
   input  logic i_sda,
   output logic o_scl_rise,
   output logic o_scl_fall,
   output logic o_start,
   output logic o_stop,
   output logic o_sda_s
);

   logic [SYNC_STAGES-1:0] r_scl_sync;
   logic [SYNC_STAGES-1:0] r_sda_sync;
   logic                   r_scl_d;
   logic                   r_sda_d;
   logic                   r_scl_rise;
   logic                   r_scl_fall;
   logic                   r_start;
   logic                   r_stop;
   logic                   r_sda_s;
   logic                   w_scl_s;
   logic                   w_sda_s;

   assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
   assign w_sda_s = r_sda_sync[SYNC_STAGES-1];

   // Idle bus is high, so history resets to 1 to avoid a false START out of reset
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_d    <= 1'b1;
         r_sda_d    <= 1'b1;
         r_scl_rise <= 1'b0;
         r_scl_fall <= 1'b0;
         r_start    <= 1'b0;
         r_stop     <= 1'b0;
         r_sda_s    <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
         r_scl_d    <= w_scl_s;
         r_sda_d    <= w_sda_s;
         r_scl_rise <= w_scl_s & ~r_scl_d;
         r_scl_fall <= ~w_scl_s & r_scl_d;
         r_start    <= w_scl_s & r_scl_d & r_sda_d & ~w_sda_s;
         r_stop     <= w_scl_s & r_scl_d & ~r_sda_d & w_sda_s;
         r_sda_s    <= w_sda_s;
      end
   end

   assign o_scl_rise = r_scl_rise;
   assign o_scl_fall = r_scl_fall;
   assign o_start    = r_start;
   assign o_stop     = r_stop;
   assign o_sda_s    = r_sda_s;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target exposing a sub-addressed 8-bit register port; single and sequential read/write.
module i2c_slave_responder
   import i2c_pkg::*;
#(
   parameter logic [6:0]  SLAVE_ADDR  = I2C_DEFAULT_ADDR,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       i_clk,
   input  logic       reset_n,
   input  logic       scl_i,
   inout  wire        sda_o,
   output logic [7:0] o_reg_addr,
   output logic [7:0] o_reg_wdata,
   output logic       o_reg_we,
   output logic       o_reg_re,
   input  logic [7:0] i_reg_rdata,
   output logic       o_busy,
   output logic       o_start_det,
   output logic       o_stop_det
);

   logic                   w_scl_rise, w_scl_fall, w_start, w_stop, w_sda_s;
   logic [I2C_STATE_W-1:0] r_state, w_state;
   logic [3:0]             r_bit_cnt, w_bit_cnt;
   logic [7:0]             r_shift, w_shift;
   logic [7:0]             r_ptr, w_ptr;
   logic [7:0]             r_wdata, w_wdata;
   logic [7:0]             w_byte_in;
   logic                   r_sda_low, w_sda_low;
   logic                   r_busy, w_busy;
   logic                   r_rw, w_rw;
   logic                   r_mack, w_mack;
   logic                   r_we, w_we;
   logic                   r_re, w_re;
   logic                   r_re_d;
   logic                   r_start_det, r_stop_det;

   i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .i_clk      (i_clk),
      .i_rst_n    (reset_n),
      .i_scl      (scl_i),
      .i_sda      (sda_o),
      .o_scl_rise (w_scl_rise),
      .o_scl_fall (w_scl_fall),
      .o_start    (w_start),
      .o_stop     (w_stop),
      .o_sda_s    (w_sda_s)
   );

   assign sda_o = r_sda_low ? 1'b0 : 1'bz;

   always_ff @(posedge i_clk) begin
      if (!reset_n) begin
         r_state     <= I2C_ST_IDLE;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_ptr       <= '0;
         r_wdata     <= '0;
         r_sda_low   <= 1'b0;
         r_busy      <= 1'b0;
         r_rw        <= 1'b0;
         r_mack      <= 1'b0;
         r_we        <= 1'b0;
         r_re        <= 1'b0;
         r_re_d      <= 1'b0;
         r_start_det <= 1'b0;
         r_stop_det  <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_bit_cnt   <= w_bit_cnt;
         r_shift     <= w_shift;
         r_ptr       <= w_ptr;
         r_wdata     <= w_wdata;
         r_sda_low   <= w_sda_low;
         r_busy      <= w_busy;
         r_rw        <= w_rw;
         r_mack      <= w_mack;
         r_we        <= w_we;
         r_re        <= w_re;
         r_re_d      <= r_re;
         r_start_det <= w_start;
         r_stop_det  <= w_stop;
      end
   end

   // Bus conditions override any bit activity in the same cycle
   always_comb begin
      w_state   = r_state;
      w_bit_cnt = r_bit_cnt;
      w_shift   = r_shift;
      w_ptr     = r_ptr;
      w_wdata   = r_wdata;
      w_sda_low = r_sda_low;
      w_busy    = r_busy;
      w_rw      = r_rw;
      w_mack    = r_mack;
      w_we      = 1'b0;
      w_re      = 1'b0;
      w_byte_in = {r_shift[6:0], w_sda_s};
      if (w_stop) begin
         w_state   = I2C_ST_IDLE;
         w_bit_cnt = '0;
         w_sda_low = 1'b0;
         w_busy    = 1'b0;
      end else if (w_start) begin
         w_state   = I2C_ST_ADDR;
         w_bit_cnt = '0;
         w_sda_low = 1'b0;
         w_busy    = 1'b0;
      end else begin
         case (r_state)
            I2C_ST_ADDR, I2C_ST_SUB, I2C_ST_WR_DATA: begin
               if (w_scl_rise) begin
                  w_shift   = w_byte_in;
                  w_bit_cnt = r_bit_cnt + 4'd1;
                  if (r_state == I2C_ST_WR_DATA && r_bit_cnt == 4'd7) begin
                     w_we    = 1'b1;
                     w_wdata = w_byte_in;
                  end
               end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                  w_bit_cnt = '0;
                  w_sda_low = 1'b1;
                  if (r_state == I2C_ST_ADDR) begin
                     if (i2c_addr_match(r_shift, SLAVE_ADDR)) begin
                        w_state = I2C_ST_ADDR_ACK;
                        w_busy  = 1'b1;
                        w_rw    = r_shift[0];
                     end else begin
                        w_state   = I2C_ST_IGNORE;
                        w_sda_low = 1'b0;
                     end
                  end else if (r_state == I2C_ST_SUB) begin
                     w_ptr   = r_shift;
                     w_state = I2C_ST_SUB_ACK;
                  end else begin
                     w_state = I2C_ST_WR_ACK;
                  end
               end
            end
            I2C_ST_ADDR_ACK: begin
               // On a read, sda stays low until the first data bit replaces the ACK
               if (w_scl_fall) begin
                  if (r_rw == I2C_RW_WRITE) begin
                     w_state   = I2C_ST_SUB;
                     w_sda_low = 1'b0;
                  end else begin
                     w_state = I2C_ST_RD_DATA;
                     w_re    = 1'b1;
                  end
               end
            end
            I2C_ST_SUB_ACK: begin
               if (w_scl_fall) begin
                  w_state   = I2C_ST_WR_DATA;
                  w_sda_low = 1'b0;
               end
            end
            I2C_ST_WR_ACK: begin
               if (w_scl_fall) begin
                  w_state   = I2C_ST_WR_DATA;
                  w_sda_low = 1'b0;
                  w_ptr     = r_ptr + 8'd1;
               end
            end
            I2C_ST_RD_DATA: begin
               if (r_re_d) begin
                  w_shift   = i_reg_rdata;
                  w_sda_low = ~i_reg_rdata[7];
                  w_bit_cnt = '0;
               end else if (w_scl_fall) begin
                  w_bit_cnt = r_bit_cnt + 4'd1;
                  w_shift   = {r_shift[6:0], 1'b0};
                  if (r_bit_cnt == 4'd7) begin
                     w_state   = I2C_ST_RD_ACK;
                     w_sda_low = 1'b0;
                  end else begin
                     w_sda_low = ~r_shift[6];
                  end
               end
            end
            I2C_ST_RD_ACK: begin
               // ACK sampled high-phase; next byte fetched once scl is low again
               if (w_scl_rise) begin
                  w_mack = w_sda_s;
               end else if (w_scl_fall) begin
                  if (r_mack == I2C_NACK) begin
                     w_state = I2C_ST_IGNORE;
                  end else begin
                     w_state = I2C_ST_RD_DATA;
                     w_ptr   = r_ptr + 8'd1;
                     w_re    = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign o_reg_addr  = r_ptr;
   assign o_reg_wdata = r_wdata;
   assign o_reg_we    = r_we;
   assign o_reg_re    = r_re;
   assign o_busy      = r_busy;
   assign o_start_det = r_start_det;
   assign o_stop_det  = r_stop_det;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: bit-level I2C master, register-file model, vector table and corner sequences.
module tb_i2c_slave_responder;
   import i2c_pkg::*;

   localparam int unsigned Q = 10;

   typedef struct {
      logic [7:0] hdr;
      logic [7:0] sub;
      logic [7:0] data;
      logic       exp_nack;
   } wr_vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic       scl;
   logic       m_sda_low;
   wire        sda;
   logic [7:0] reg_addr, reg_wdata;
   logic [7:0] reg_rdata = 8'h00;
   logic       reg_we, reg_re, busy, start_det, stop_det;

   pullup (sda);
   assign sda = m_sda_low ? 1'b0 : 1'bz;

   i2c_slave_responder #(.SLAVE_ADDR(7'h5C), .SYNC_STAGES(2)) dut (
      .i_clk       (clk),
      .reset_n     (reset_n),
      .scl_i       (scl),
      .sda_o       (sda),
      .o_reg_addr  (reg_addr),
      .o_reg_wdata (reg_wdata),
      .o_reg_we    (reg_we),
      .o_reg_re    (reg_re),
      .i_reg_rdata (reg_rdata),
      .o_busy      (busy),
      .o_start_det (start_det),
      .o_stop_det  (stop_det)
   );

   logic [7:0] mem [256];
   logic [7:0] q_we_addr [$];
   logic [7:0] q_we_data [$];
   int we_cnt = 0, re_cnt = 0, start_cnt = 0, stop_cnt = 0, both_cnt = 0, slave_low_cnt = 0;
   int n_tests = 0, n_fail = 0;

   // Register-file model with one-cycle read latency, plus event counters
   always @(posedge clk) begin
      if (reg_we) begin
         mem[reg_addr] <= reg_wdata;
         q_we_addr.push_back(reg_addr);
         q_we_data.push_back(reg_wdata);
         we_cnt <= we_cnt + 1;
      end
      if (reg_re) begin
         reg_rdata <= mem[reg_addr];
         re_cnt    <= re_cnt + 1;
      end
      if (start_det)                 start_cnt     <= start_cnt + 1;
      if (stop_det)                  stop_cnt      <= stop_cnt + 1;
      if (reg_we && reg_re)          both_cnt      <= both_cnt + 1;
      if (!m_sda_low && sda == 1'b0) slave_low_cnt <= slave_low_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_q(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic m_start();
      m_sda_low = 1'b1; wait_q(Q);
      scl = 1'b0;       wait_q(Q);
   endtask

   task automatic m_rstart();
      m_sda_low = 1'b0; wait_q(Q);
      scl = 1'b1;       wait_q(Q);
      m_sda_low = 1'b1; wait_q(Q);
      scl = 1'b0;       wait_q(Q);
   endtask

   task automatic m_stop();
      m_sda_low = 1'b1; wait_q(Q);
      scl = 1'b1;       wait_q(Q);
      m_sda_low = 1'b0; wait_q(2 * Q);
   endtask

   task automatic m_bit_write(input logic b);
      m_sda_low = ~b; wait_q(Q);
      scl = 1'b1;     wait_q(2 * Q);
      scl = 1'b0;     wait_q(Q);
   endtask

   task automatic m_bit_read(output logic b);
      m_sda_low = 1'b0; wait_q(Q);
      scl = 1'b1;       wait_q(Q);
      b = sda;          wait_q(Q);
      scl = 1'b0;       wait_q(Q);
   endtask

   task automatic m_write_byte(input logic [7:0] d, output logic nack);
      for (int i = 7; i >= 0; i--) m_bit_write(d[i]);
      m_bit_read(nack);
   endtask

   task automatic m_read_byte(output logic [7:0] d, input logic nack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         m_bit_read(b);
         d[i] = b;
      end
      m_bit_write(nack);
   endtask

   wr_vec_t    vecs [6];
   logic       nack;
   logic [7:0] rd0, rd1;
   logic [7:0] exp_ptr;
   int         we0, re0, st0, sp0, sl0, qn;

   initial begin
      vecs[0] = '{hdr: 8'hB8, sub: 8'h1F, data: 8'hA5, exp_nack: 1'b0};
      vecs[1] = '{hdr: 8'hBA, sub: 8'h33, data: 8'h44, exp_nack: 1'b1};
      vecs[2] = '{hdr: 8'hB8, sub: 8'h00, data: 8'h5A, exp_nack: 1'b0};
      vecs[3] = '{hdr: 8'h38, sub: 8'h01, data: 8'h02, exp_nack: 1'b1};
      vecs[4] = '{hdr: 8'hB8, sub: 8'h80, data: 8'hFF, exp_nack: 1'b0};
      vecs[5] = '{hdr: 8'hBC, sub: 8'h55, data: 8'h66, exp_nack: 1'b1};
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      exp_ptr   = 8'h00;
      reset_n   = 1'b0;
      scl       = 1'b1;
      m_sda_low = 1'b0;
      wait_q(5);
      check("rst reg_addr", 32'(reg_addr), 32'h00);
      check("rst we_re_busy", {29'd0, reg_we, reg_re, busy}, 32'h0);
      check("rst det", {30'd0, start_det, stop_det}, 32'h0);
      check("rst sda released", 32'(sda), 32'h1);
      reset_n = 1'b1;
      wait_q(10);
      check("idle no start", 32'(start_cnt), 32'h0);

      // Single-byte write transactions, matching and non-matching addresses
      for (int i = 0; i < 6; i++) begin
         we0 = we_cnt; st0 = start_cnt; sp0 = stop_cnt; sl0 = slave_low_cnt;
         qn  = q_we_addr.size();
         m_start();
         m_write_byte(vecs[i].hdr, nack);
         check($sformatf("v%0d addr nack", i), 32'(nack), 32'(vecs[i].exp_nack));
         check($sformatf("v%0d busy", i), 32'(busy), 32'(!vecs[i].exp_nack));
         if (!vecs[i].exp_nack) begin
            m_write_byte(vecs[i].sub, nack);
            check($sformatf("v%0d sub ack", i), 32'(nack), 32'(I2C_ACK));
            m_write_byte(vecs[i].data, nack);
            check($sformatf("v%0d data ack", i), 32'(nack), 32'(I2C_ACK));
            exp_ptr = vecs[i].sub + 8'd1;
         end
         m_stop();
         check($sformatf("v%0d we count", i), 32'(we_cnt - we0), vecs[i].exp_nack ? 32'd0 : 32'd1);
         if (!vecs[i].exp_nack) begin
            check($sformatf("v%0d we addr", i), 32'(q_we_addr[qn]), 32'(vecs[i].sub));
            check($sformatf("v%0d we data", i), 32'(q_we_data[qn]), 32'(vecs[i].data));
         end else begin
            check($sformatf("v%0d sda untouched", i), 32'(slave_low_cnt - sl0), 32'd0);
         end
         check($sformatf("v%0d start det", i), 32'(start_cnt - st0), 32'd1);
         check($sformatf("v%0d stop det", i), 32'(stop_cnt - sp0), 32'd1);
         check($sformatf("v%0d busy after stop", i), 32'(busy), 32'd0);
         check($sformatf("v%0d pointer", i), 32'(reg_addr), 32'(exp_ptr));
      end

      // Sequential write with pointer wrap
      qn = q_we_addr.size(); we0 = we_cnt;
      m_start();
      m_write_byte(8'hB8, nack);
      m_write_byte(8'hFE, nack);
      m_write_byte(8'h11, nack);
      m_write_byte(8'h22, nack);
      m_write_byte(8'h33, nack);
      m_stop();
      check("seq we count", 32'(we_cnt - we0), 32'd3);
      check("seq addr0", 32'(q_we_addr[qn]),     32'hFE);
      check("seq addr1", 32'(q_we_addr[qn + 1]), 32'hFF);
      check("seq addr2", 32'(q_we_addr[qn + 2]), 32'h00);
      check("seq data2", 32'(q_we_data[qn + 2]), 32'h33);
      check("seq pointer", 32'(reg_addr), 32'h01);

      // Load 0x3C/0xC3, then sub-address write, repeated START, two-byte read
      m_start();
      m_write_byte(8'hB8, nack);
      m_write_byte(8'h10, nack);
      m_write_byte(8'h3C, nack);
      m_write_byte(8'hC3, nack);
      m_stop();
      re0 = re_cnt; st0 = start_cnt;
      m_start();
      m_write_byte(8'hB8, nack);
      m_write_byte(8'h10, nack);
      m_rstart();
      m_write_byte(8'hB9, nack);
      check("rd addr ack", 32'(nack), 32'(I2C_ACK));
      m_read_byte(rd0, I2C_ACK);
      m_read_byte(rd1, I2C_NACK);
      m_stop();
      check("rd byte0", 32'(rd0), 32'h3C);
      check("rd byte1", 32'(rd1), 32'hC3);
      check("rd re count", 32'(re_cnt - re0), 32'd2);
      check("rd start dets", 32'(start_cnt - st0), 32'd2);
      check("rd pointer", 32'(reg_addr), 32'h11);
      check("rd busy after stop", 32'(busy), 32'd0);

      // STOP after four data bits discards the partial byte
      we0 = we_cnt; sp0 = stop_cnt;
      m_start();
      m_write_byte(8'hB8, nack);
      m_write_byte(8'h40, nack);
      for (int i = 0; i < 4; i++) m_bit_write(1'b1);
      m_stop();
      check("abort no we", 32'(we_cnt - we0), 32'd0);
      check("abort stop det", 32'(stop_cnt - sp0), 32'd1);
      check("abort busy", 32'(busy), 32'd0);
      qn = q_we_addr.size();
      m_start();
      m_write_byte(8'hB8, nack);
      m_write_byte(8'h40, nack);
      m_write_byte(8'h77, nack);
      m_stop();
      check("post-abort we count", 32'(we_cnt - we0), 32'd1);
      check("post-abort we addr", 32'(q_we_addr[qn]), 32'h40);
      check("post-abort we data", 32'(q_we_data[qn]), 32'h77);

      // Reset while the slave drives the first read bit (mem[0x20] = 0x00)
      m_start();
      m_write_byte(8'hB8, nack);
      m_write_byte(8'h20, nack);
      m_rstart();
      m_write_byte(8'hB9, nack);
      check("mid-read sda driven", 32'(sda), 32'h0);
      check("mid-read busy", 32'(busy), 32'h1);
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      check("reset sda released", 32'(sda), 32'h1);
      check("reset reg_addr", 32'(reg_addr), 32'h00);
      check("reset strobes", {28'd0, reg_we, reg_re, busy, start_det}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      wait_q(Q);
      m_stop();
      check("we/re exclusive", 32'(both_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
